rand_draw_arbiter: RTL
======================

# rand_draw_arbiter

Shares one 32-bit XNOR LFSR between up to NREQ random-number consumers in the Tetris game, such as the next-piece generator and the garbage-row/column picker. It runs a round-robin grant, steps the LFSR a fixed number of times per draw, and extracts a VW-bit value. Rejection sampling keeps each value uniformly below the requester's bound. It is the only owner of the game's random state.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4).
- VW, 3: value width; bound width is VW+1.
- STEPS, 8: LFSR shifts per draw.
- MAX_TRY, 4: draws before forced fallback.
- FREE_RUN, 0: 1 means the LFSR also steps every S_IDLE cycle, so player timing adds entropy.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- req, in, NREQ: per-requester draw request, level, held until ack.
- bound, in, NREQ x (VW+1): exclusive upper limit per requester, sampled at grant; 0 is treated as 1.
- ack, out, NREQ: one-cycle pulse, one-hot, value valid in the same cycle.
- value, out, VW: drawn value, held until the next ack.
- busy, out, 1: high in S_STEP and S_CHECK.

## Operation
- LFSR step rule: state <= {xn, state[31:1]}, where xn = ~(s[31]^s[21]^s[1]^s[0]). The all-zero state is legal, and reset loads zero.
- Raw draw: r = state[31:32-VW], the top VW bits.
- States:
  - S_IDLE: if any unmasked req is high, grant the first requester at or after ptr (round-robin). Latch owner and bound, clear step_cnt and try_cnt, go to S_STEP.
  - S_STEP: the LFSR steps every cycle. After STEPS steps, go to S_CHECK.
  - S_CHECK: if r < bound, register ack[owner]=1 and value=r, and go to S_IDLE. Otherwise increment try_cnt. If try_cnt reaches MAX_TRY, register ack with value=0 and go to S_IDLE; otherwise clear step_cnt and return to S_STEP.
- Pointer update: ptr <= owner+1 mod NREQ, applied on the ack edge.
- Masking: a requester whose ack is high in the current cycle is masked from arbitration at that edge. A requester that holds req afterwards gets a new draw.
- Bound width: bound is compared at VW+1 bits, so bound = 2^VW accepts every r.
- FREE_RUN=0: the LFSR is frozen outside S_STEP.
- req dropping before ack: the draw completes anyway, and the ack is still issued.
- Bound changes after grant are ignored.

## Timing
- Reset state, applied immediately on assertion: S_IDLE, LFSR=0, ptr=0, ack=0, value=0, busy=0, counters=0.
- Reset mid-draw aborts the draw with no ack and no partial state.
- Latency, with req sampled at edge E0:
  - The LFSR steps at E1..E STEPS.
  - The check occurs at E(STEPS+1); ack is high for one cycle after that edge.
  - Each rejection adds STEPS+1 cycles.
  - Worst case is MAX_TRY*(STEPS+1) cycles.
- busy rises after E0 and falls at the ack edge.
- Back-to-back: a second requester waiting at the ack edge is granted at that same edge, because S_IDLE lasts one cycle.

## Structure
- Shared package rand_pkg holds:
  - LFSR_W=32.
  - Tap positions 31/21/1/0.
  - The state enum {S_IDLE,S_STEP,S_CHECK}.
  - Helper function rr_pick(req, ptr).
- One sub-module, lfsr32_step: 32-bit register with enable, asynchronous active-low reset to zero, and XNOR feedback. The arbiter FSM, counters and compare live in rand_draw_arbiter.

## Test plan
Raw draws from reset with STEPS=8 are 2, 6, 4 (LFSR 0x55000000 after 8 steps).

1. Reset, FREE_RUN=0, req[0]=1, bound[0]=7 -> ack[0] 9 cycles after the sampling edge, value=2, busy high for exactly 9 cycles.
2. After test 1, req[1]=1, bound[1]=5 -> 6 is rejected, then 4 is accepted. ack[1] arrives 18 cycles after grant with value=4, and ptr returns to 0.
3. From reset, req[0] and req[1] both held high with bound 8 -> grants alternate 0,1,0,1. Values are 2, 6, 4, ...; acks are spaced 9 cycles apart.
4. From reset, bound[0]=1, MAX_TRY=2 -> 2 and 6 are both rejected, forced value=0, ack at 18 cycles.
5. Assert reset during S_STEP of a draw -> ack never pulses, busy=0 and value=0 immediately. A new req then returns 2 again.
6. FREE_RUN=1, idle 3 cycles after reset, then req[0] with bound 8 -> value = top 3 bits after 11 steps = b11,b10,b9 = 1,0,1 = 5.

Source files
------------

// File: rtl/rand_pkg.sv
// -----------------------------------------------------------------------------
// rand_pkg
// Shared definitions for the game's random-number arbiter: LFSR width and
// feedback taps, the draw FSM state type, and the round-robin pick helper.
// No ports (package).
// -----------------------------------------------------------------------------
package rand_pkg;

   localparam int LFSR_W   = 32;
   localparam int TAP_A    = 31;
   localparam int TAP_B    = 21;
   localparam int TAP_C    = 1;
   localparam int TAP_D    = 0;

   // Arbitration is always done on a 4-wide vector; unused requester slots
   // are tied to zero so the scan order still matches "mod NREQ".
   localparam int MAX_NREQ = 4;
   localparam int PTR_W    = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STEP  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   typedef struct packed {
      logic             found;
      logic [PTR_W-1:0] idx;
   } pick_t;

   // First set bit of req at or after ptr, wrapping. Scanning from the far
   // end backwards lets the nearest candidate overwrite the others.
   function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                     input logic [PTR_W-1:0]    ptr);
      pick_t            p;
      logic [PTR_W-1:0] idx;
      p = '0;
      for (int i = MAX_NREQ - 1; i >= 0; i--) begin
         idx = ptr + PTR_W'(i);
         if (req[idx]) begin
            p.found = 1'b1;
            p.idx   = idx;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/lfsr32_step.sv
// -----------------------------------------------------------------------------
// lfsr32_step
// 32-bit XNOR LFSR, shifting right with the feedback bit entering at the top.
// The all-zero state is legal (XNOR feedback), so reset loads zero.
// Ports:
//   clk   in   rising-edge clock
//   reset in   asynchronous active-low reset, clears the register
//   en    in   advance the LFSR by one step this cycle
//   msbs  out  top OUT_W bits of the current state
// -----------------------------------------------------------------------------
module lfsr32_step
   import rand_pkg::*;
#(
   parameter int OUT_W = LFSR_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [OUT_W-1:0] msbs
);

   logic [LFSR_W-1:0] state;
   logic              xn;

   assign xn   = ~(state[TAP_A] ^ state[TAP_B] ^ state[TAP_C] ^ state[TAP_D]);
   assign msbs = state[LFSR_W-1 -: OUT_W];

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= '0;
      end else if (en) begin
         state <= {xn, state[LFSR_W-1:1]};
      end
   end

endmodule

// File: rtl/rand_draw_arbiter.sv
// -----------------------------------------------------------------------------
// rand_draw_arbiter
// Sole owner of the game's random state. Round-robin arbitrates up to NREQ
// consumers onto one LFSR, steps it STEPS times per draw, and rejection-samples
// the top VW bits against the winner's bound. After MAX_TRY rejections the
// draw is forced to 0.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   req    in   [NREQ]         per-requester level request, held until ack
//   bound  in   [NREQ][VW+1]   exclusive upper limit, sampled at grant (0 -> 1)
//   ack    out  [NREQ]         one-cycle one-hot pulse, value valid with it
//   value  out  [VW]           drawn value, held until the next ack
//   busy   out                 high while a draw is in progress
// -----------------------------------------------------------------------------
module rand_draw_arbiter
   import rand_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int VW       = 3,
   parameter int STEPS    = 8,
   parameter int MAX_TRY  = 4,
   parameter int FREE_RUN = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0][VW:0] bound,
   output logic [NREQ-1:0]       ack,
   output logic [VW-1:0]         value,
   output logic                  busy
);

   localparam int SW = $clog2(STEPS + 1);
   localparam int TW = $clog2(MAX_TRY + 1);

   localparam logic [VW:0]          B_ONE  = 1;
   localparam logic [MAX_NREQ-1:0]  OH_ONE = 1;

   state_t                    state, state_nxt;
   logic                      lfsr_en;
   logic [VW-1:0]             r;
   logic [PTR_W-1:0]          owner, ptr, owner_inc, arb_ptr;
   logic [VW:0]               bound_q, bound_pick;
   logic [SW-1:0]             step_cnt;
   logic [TW-1:0]             try_cnt;
   logic [MAX_NREQ-1:0]       req_pad, ack_pad, owner_oh, cand;
   logic [MAX_NREQ-1:0][VW:0] bound_pad;
   logic                      accept, last_step, last_try, done, grant;
   pick_t                     pick;

   lfsr32_step #(.OUT_W(VW)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (lfsr_en),
      .msbs  (r)
   );

   // Widen the per-requester vectors to the fixed arbitration width.
   always_comb begin
      // NOTE: each combinational output is given a default before any
      // conditional/partial assignment, so no latch can be inferred.
      req_pad   = '0;
      ack_pad   = '0;
      bound_pad = '0;
      req_pad[NREQ-1:0] = req;
      ack_pad[NREQ-1:0] = ack;
      for (int i = 0; i < NREQ; i++) begin
         bound_pad[i] = bound[i];
      end
   end

   assign owner_oh  = OH_ONE << owner;
   assign owner_inc = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + PTR_W'(1);

   // Compare at VW+1 bits so bound = 2^VW accepts every raw value.
   assign accept    = {1'b0, r} < bound_q;
   assign last_step = (step_cnt == SW'(STEPS - 1));
   assign last_try  = (try_cnt == TW'(MAX_TRY - 1));
   assign done      = (state == S_CHECK) && (accept || last_try);

   // Two arbitration slots: in S_IDLE the requester whose ack is still high
   // is masked; at a completion edge the finishing owner is masked so a
   // waiting peer is granted on that same edge with no idle gap.
   assign cand       = (state == S_IDLE) ? (req_pad & ~ack_pad) : (req_pad & ~owner_oh);
   assign arb_ptr    = (state == S_IDLE) ? ptr : owner_inc;
   assign pick       = rr_pick(cand, arb_ptr);
   assign grant      = ((state == S_IDLE) || done) && pick.found;
   assign bound_pick = (bound_pad[pick.idx] == '0) ? B_ONE : bound_pad[pick.idx];

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant)     state_nxt = S_STEP;
         S_STEP:  if (last_step) state_nxt = S_CHECK;
         S_CHECK: state_nxt = (!done || grant) ? S_STEP : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy    = (state == S_STEP) || (state == S_CHECK);
      lfsr_en = (state == S_STEP) || ((FREE_RUN != 0) && (state == S_IDLE));
   end

   // Draw datapath: ownership, pointer, counters and registered result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner    <= '0;
         ptr      <= '0;
         bound_q  <= '0;
         step_cnt <= '0;
         try_cnt  <= '0;
         ack      <= '0;
         value    <= '0;
      end else begin
         ack <= '0;
         if (done) begin
            ack   <= owner_oh[NREQ-1:0];
            value <= accept ? r : '0;
            ptr   <= owner_inc;
         end
         if (grant) begin
            owner    <= pick.idx;
            bound_q  <= bound_pick;
            step_cnt <= '0;
            try_cnt  <= '0;
         end else if (state == S_STEP) begin
            step_cnt <= step_cnt + SW'(1);
         end else if ((state == S_CHECK) && !done) begin
            try_cnt  <= try_cnt + TW'(1);
            step_cnt <= '0;
         end
      end
   end

endmodule
